twiddle_index_seq: RTL and testbench
====================================

Name: twiddle_index_seq

Overview:
- Generates per-stage twiddle ROM indexes for the streaming radix-2 DIF FFT pipeline.
- Drives the `indexes` input of the twiddle ROM block, which returns `twiddles` one cycle later.
- Each butterfly stage has its own sample counter, advanced by that stage's valid strobe, so stages with different pipeline delays stay aligned.
- The final stage (trivial twiddle W^0) is not served.

Parameters:
- FFT_SIZE, 16, transform length; power of two, at least 4.
- Derived (localparam, not overridable):
  - L = $clog2(FFT_SIZE)
  - S = L-1, number of served stages
  - W = L-1, index width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear of all stage counters; frame resync
- stage_valid  input  [S-1:0]  one sample entering stage s multiplier this cycle
- indexes  output  [S-1:0][W-1:0]  twiddle ROM index per stage; same packed shape as the ROM's `indexes` input
- idx_valid  output  [S-1:0]  indexes[s] is valid this cycle
- mul_en  output  [S-1:0]  stage s sample is in the twiddle-multiplied half

Behaviour:
- Reset: rst=1 at a clk edge clears the following; rst has priority over flush and stage_valid.
  - cnt[s] = 0 (L bits each)
  - indexes = 0
  - idx_valid = 0
  - mul_en = 0
- Span: span_s = FFT_SIZE >> (s+1). Stage 0 span = N/2; stage S-1 span = 2.
- Per-stage counter: on stage_valid[s]=1, cnt[s] <= cnt[s]+1 modulo FFT_SIZE.
  - Wraps FFT_SIZE-1 -> 0 with no stall.
  - Counters are independent; simultaneous valids on any subset of stages are all honoured in the same cycle.
- Registered outputs, 1-cycle latency from stage_valid[s] and using the pre-increment cnt[s]:
  - idx_valid[s] <= stage_valid[s]
  - mul_en[s] <= cnt[s][L-1-s]
  - indexes[s] <= mul_en ? ((cnt[s] mod span_s) << s) : 0
  - Index range 0..N/2-1; the shift never overflows W bits.
- When stage_valid[s]=0:
  - indexes[s] and mul_en[s] hold their previous values.
  - idx_valid[s] = 0.
- End-to-end latency: stage_valid[s] to twiddles[s] at the ROM output = 2 cycles. The datapath delays stage data by 2 cycles to match.
- flush=1 (with rst=0):
  - All cnt <= 0.
  - idx_valid <= 0; stage_valid in the same cycle is ignored.
  - indexes and mul_en hold.
  - On the next valid after flush, stage s restarts at sample 0.
- Mid-frame rst or flush discards the partial frame; no recovery state.
- No backpressure. stage_valid may be asserted every cycle, or with arbitrary gaps.

Optional Feature:
- Macro: TWIDDLE_IDX_FRAME_END_EN.
- Defined:
  - Adds output frame_end [S-1:0], registered, reset 0.
  - frame_end[s] pulses for one cycle, aligned with idx_valid[s], when the consumed cnt[s] == FFT_SIZE-1 (last sample of a frame).
  - flush clears it.
- Undefined: port absent. All other behaviour is identical.

Test Plan (FFT_SIZE=16: S=3, W=3):
- Reset: hold rst 3 cycles with stage_valid=3'b111 -> indexes=0, idx_valid=0, mul_en=0 throughout; cnt=0 after release.
- Stage 0 full frame: stage_valid[0]=1 for 16 cycles -> one cycle later, samples 0..7 give mul_en=0, idx=0; samples 8..15 give mul_en=1, idx=0,1,...,7.
- Stage 1 and stage 2, with all stages valid every cycle for 16 cycles:
  - Stage 1: idx = 0,0,0,0, 0,2,4,6, 0,0,0,0, 0,2,4,6.
  - Stage 2: idx = 0,0,0,4 repeated 4 times; mul_en=1 on samples 2,3 of each group of 4.
- Gaps and wrap: stage_valid[0] toggling 1,0,1,0 for 40 cycles -> counter advances only on valid cycles; idx/mul_en hold during gaps; after 16 valids cnt wraps and sample 16 gives idx=0, mul_en=0.
- Flush mid-frame: 11 valids on stage 0, then flush=1 with stage_valid[0]=1 -> no idx_valid next cycle; next valid gives sample 0 (mul_en=0); 8 valids later idx=0 with mul_en=1.
- TWIDDLE_IDX_FRAME_END_EN defined, continuous valid on stage 2 for 32 cycles -> frame_end[2] pulses exactly twice, on the idx_valid of samples 15 and 31; rst mid-frame -> no pulse until 16 fresh valids.

Source files
------------

// File: rtl/twiddle_index_seq.sv
// Per-stage twiddle ROM index sequencer for a streaming radix-2 DIF FFT.
// Optional frame_end output is enabled by defining TWIDDLE_IDX_FRAME_END_EN.
module twiddle_index_seq #(
    parameter  int FFT_SIZE = 16,
    localparam int L = $clog2(FFT_SIZE),
    localparam int S = L - 1,
    localparam int W = L - 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [S-1:0]        stage_valid,
    output logic [S-1:0][W-1:0] indexes,
    output logic [S-1:0]        idx_valid,
`ifdef TWIDDLE_IDX_FRAME_END_EN
    output logic [S-1:0]        frame_end,
`endif
    output logic [S-1:0]        mul_en
);

    // Stage s walks twiddles W^(k*2^s) for k in 0..span_s-1, span_s = N >> (s+1).
    function automatic logic [W-1:0] stage_index(input logic [L-1:0] cnt, input int s);
        logic [L-1:0] masked;
        masked = cnt & L'((FFT_SIZE >> (s + 1)) - 1);
        return W'(masked << s);
    endfunction

    logic [S-1:0][L-1:0] cnt_q, cnt_d;
    logic [S-1:0][W-1:0] indexes_q, indexes_d;
    logic [S-1:0]        idx_valid_q, idx_valid_d;
    logic [S-1:0]        mul_en_q, mul_en_d;
`ifdef TWIDDLE_IDX_FRAME_END_EN
    logic [S-1:0]        frame_end_q, frame_end_d;
`endif

    always_comb begin
        cnt_d       = cnt_q;
        indexes_d   = indexes_q;
        mul_en_d    = mul_en_q;
        idx_valid_d = '0;
`ifdef TWIDDLE_IDX_FRAME_END_EN
        frame_end_d = '0;
`endif
        if (flush) begin
            cnt_d = '0;
        end else begin
            for (int s = 0; s < S; s++) begin
                if (stage_valid[s]) begin
                    cnt_d[s]       = cnt_q[s] + L'(1);
                    idx_valid_d[s] = 1'b1;
                    // The top bit of the stage's butterfly span selects the lower (multiplied) leg.
                    mul_en_d[s]    = cnt_q[s][L-1-s];
                    indexes_d[s]   = cnt_q[s][L-1-s] ? stage_index(cnt_q[s], s) : '0;
`ifdef TWIDDLE_IDX_FRAME_END_EN
                    frame_end_d[s] = (cnt_q[s] == L'(FFT_SIZE - 1));
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            indexes_q   <= '0;
            idx_valid_q <= '0;
            mul_en_q    <= '0;
`ifdef TWIDDLE_IDX_FRAME_END_EN
            frame_end_q <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            indexes_q   <= indexes_d;
            idx_valid_q <= idx_valid_d;
            mul_en_q    <= mul_en_d;
`ifdef TWIDDLE_IDX_FRAME_END_EN
            frame_end_q <= frame_end_d;
`endif
        end
    end

    assign indexes   = indexes_q;
    assign idx_valid = idx_valid_q;
    assign mul_en    = mul_en_q;
`ifdef TWIDDLE_IDX_FRAME_END_EN
    assign frame_end = frame_end_q;
`endif

endmodule

// File: tb/tb_twiddle_index_seq.sv
// Bench for twiddle_index_seq: directed plan steps plus randomized traffic
// against an arithmetic sample-count model (FFT_SIZE=16).
module tb_twiddle_index_seq;

    localparam int N = 16;
    localparam int L = $clog2(N);
    localparam int S = L - 1;
    localparam int W = L - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                flush = 1'b0;
    logic [S-1:0]        stage_valid = '0;
    logic [S-1:0][W-1:0] indexes;
    logic [S-1:0]        idx_valid;
    logic [S-1:0]        mul_en;
`ifdef TWIDDLE_IDX_FRAME_END_EN
    logic [S-1:0]        frame_end;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: plain sample counts and expected registered outputs.
    int cnt_m [S];
    int idx_m [S];
    int vld_m [S];
    int mul_m [S];
    int fe_m  [S];

    twiddle_index_seq #(.FFT_SIZE(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .stage_valid (stage_valid),
        .indexes     (indexes),
        .idx_valid   (idx_valid),
`ifdef TWIDDLE_IDX_FRAME_END_EN
        .frame_end   (frame_end),
`endif
        .mul_en      (mul_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [S-1:0] sv, input logic fl, input logic rs);
        for (int s = 0; s < S; s++) begin
            int span;
            span = N >> (s + 1);
            if (rs) begin
                cnt_m[s] = 0; idx_m[s] = 0; vld_m[s] = 0; mul_m[s] = 0; fe_m[s] = 0;
            end else if (fl) begin
                cnt_m[s] = 0; vld_m[s] = 0; fe_m[s] = 0;
            end else begin
                vld_m[s] = sv[s];
                fe_m[s]  = 0;
                if (sv[s]) begin
                    mul_m[s] = (cnt_m[s] / span) % 2;
                    idx_m[s] = (mul_m[s] != 0) ? (cnt_m[s] % span) * (1 << s) : 0;
                    fe_m[s]  = (cnt_m[s] == N - 1) ? 1 : 0;
                    cnt_m[s] = (cnt_m[s] + 1) % N;
                end
            end
        end
    endtask

    task automatic cycle(input logic [S-1:0] sv, input logic fl, input logic rs);
        stage_valid = sv;
        flush       = fl;
        rst         = rs;
        @(posedge clk);
        model_edge(sv, fl, rs);
        #1;
        for (int s = 0; s < S; s++) begin
            chk($sformatf("idx[%0d]", s), int'(indexes[s]), idx_m[s]);
            chk($sformatf("vld[%0d]", s), int'(idx_valid[s]), vld_m[s]);
            chk($sformatf("mul[%0d]", s), int'(mul_en[s]), mul_m[s]);
`ifdef TWIDDLE_IDX_FRAME_END_EN
            chk($sformatf("fe[%0d]", s), int'(frame_end[s]), fe_m[s]);
`endif
        end
    endtask

    initial begin
        int s1_tbl [16];
        int k;
        s1_tbl = '{0,0,0,0, 0,2,4,6, 0,0,0,0, 0,2,4,6};
        for (int s = 0; s < S; s++) begin
            cnt_m[s] = 0; idx_m[s] = 0; vld_m[s] = 0; mul_m[s] = 0; fe_m[s] = 0;
        end

        // Reset held with all valids asserted
        for (int i = 0; i < 3; i++) begin
            cycle(3'b111, 1'b0, 1'b1);
            chk("rst_idx", int'(indexes), 0);
            chk("rst_vld", int'(idx_valid), 0);
            chk("rst_mul", int'(mul_en), 0);
        end

        // Stage 0 full frame
        for (int i = 0; i < 16; i++) begin
            cycle(3'b001, 1'b0, 1'b0);
            chk("s0_frame_vld", int'(idx_valid[0]), 1);
            chk("s0_frame_mul", int'(mul_en[0]), (i >= 8) ? 1 : 0);
            chk("s0_frame_idx", int'(indexes[0]), (i >= 8) ? i - 8 : 0);
        end

        // All stages every cycle
        cycle(3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle(3'b111, 1'b0, 1'b0);
            chk("s1_tbl_idx", int'(indexes[1]), s1_tbl[i]);
            chk("s2_tbl_idx", int'(indexes[2]), ((i % 4) == 3) ? 4 : 0);
            chk("s2_tbl_mul", int'(mul_en[2]), ((i % 4) >= 2) ? 1 : 0);
        end

        // Gaps and wrap on stage 0
        cycle(3'b000, 1'b1, 1'b0);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            if ((i % 2) == 0) begin
                cycle(3'b001, 1'b0, 1'b0);
                if (k == 15) begin
                    chk("wrap_pre_idx", int'(indexes[0]), 7);
                end
                if (k == 16) begin
                    chk("wrap_idx", int'(indexes[0]), 0);
                    chk("wrap_mul", int'(mul_en[0]), 0);
                end
                k++;
            end else begin
                cycle(3'b000, 1'b0, 1'b0);
                chk("gap_vld", int'(idx_valid[0]), 0);
            end
        end

        // Flush mid-frame
        cycle(3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) cycle(3'b001, 1'b0, 1'b0);
        chk("preflush_mul", int'(mul_en[0]), 1);
        cycle(3'b001, 1'b1, 1'b0);
        chk("flush_vld", int'(idx_valid[0]), 0);
        chk("flush_hold_mul", int'(mul_en[0]), 1);
        chk("flush_hold_idx", int'(indexes[0]), 2);
        for (int i = 0; i <= 8; i++) begin
            cycle(3'b001, 1'b0, 1'b0);
            if (i == 0) begin
                chk("postflush_s0_mul", int'(mul_en[0]), 0);
                chk("postflush_s0_idx", int'(indexes[0]), 0);
            end
            if (i == 8) begin
                chk("postflush_s8_mul", int'(mul_en[0]), 1);
                chk("postflush_s8_idx", int'(indexes[0]), 0);
            end
        end

`ifdef TWIDDLE_IDX_FRAME_END_EN
        begin
            int pulses;
            cycle(3'b000, 1'b1, 1'b0);
            pulses = 0;
            for (int i = 0; i < 32; i++) begin
                cycle(3'b100, 1'b0, 1'b0);
                if (frame_end[2]) pulses++;
                chk("fe_pos", int'(frame_end[2]), (i == 15 || i == 31) ? 1 : 0);
            end
            chk("fe_pulses", pulses, 2);
            for (int i = 0; i < 5; i++) cycle(3'b100, 1'b0, 1'b0);
            cycle(3'b100, 1'b0, 1'b1);
            for (int i = 0; i < 16; i++) begin
                cycle(3'b100, 1'b0, 1'b0);
                chk("fe_after_rst", int'(frame_end[2]), (i == 15) ? 1 : 0);
            end
        end
`endif

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            logic [S-1:0] sv;
            logic fl;
            logic rs;
            sv = S'($urandom);
            fl = ($urandom_range(0, 24) == 0);
            rs = ($urandom_range(0, 79) == 0);
            cycle(sv, fl, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
